// File: rtl/arm_mem_pkg.sv
// Shared memory-access encodings: load sizes (also used by the sign-extension
// unit), aligner FSM states and the default MFC timeout.
package arm_mem_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HALF  = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_REQ1  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Alignment legality for a load; rot_en relaxes only the word rule.
    function automatic logic is_aligned(input size_t size, input logic [2:0] low,
                                        input logic rot_en);
        logic ok;
        case (size)
            BYTE:    ok = 1'b1;
            HALF:    ok = (low[0] == 1'b0);
            WORD:    ok = rot_en || (low[1:0] == 2'b00);
            DWORD:   ok = (low == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_data_aligner_if.sv
// Load request / data-memory bundle between requester, aligner and memory.
interface load_data_aligner_if;
    import arm_mem_pkg::*;

    logic              Start;
    logic [ADDR_W-1:0] Addr;
    logic [1:0]        dataSize;
    logic              Busy;
    logic              MOV;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemData;
    logic              MFC;
    logic [DATA_W-1:0] Data;
    logic [DATA_W-1:0] DataHi;
    logic [1:0]        SizeOut;
    logic              Done;
    logic              Err;

    // Requester plus memory side (drives request and memory response).
    modport master (
        output Start, Addr, dataSize, MemData, MFC,
        input  Busy, MOV, MemAddr, Data, DataHi, SizeOut, Done, Err
    );

    // Aligner side.
    modport slave (
        input  Start, Addr, dataSize, MemData, MFC,
        output Busy, MOV, MemAddr, Data, DataHi, SizeOut, Done, Err
    );

endinterface

// File: rtl/lane_extract.sv
// Little-endian lane extraction: right-justifies and zero-fills the addressed
// byte/half of a memory word; words optionally rotate for unaligned loads.
module lane_extract
    import arm_mem_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  size_t             size,
    input  logic              rot_en,
    output logic [DATA_W-1:0] result_c
);

    logic [4:0]          byte_sh;
    logic [4:0]          half_sh;
    logic [2*DATA_W-1:0] rot_word;

    // Select and justify the requested lane.
    always_comb begin
        byte_sh  = {offset, 3'b000};
        half_sh  = {offset[1], 4'b0000};
        rot_word = {word, word} >> byte_sh;
        case (size)
            BYTE:    result_c = (word >> byte_sh) & 32'h0000_00FF;
            HALF:    result_c = (word >> half_sh) & 32'h0000_FFFF;
            WORD:    result_c = rot_en ? rot_word[DATA_W-1:0] : word;
            default: result_c = word;
        endcase
    end

endmodule

// File: rtl/load_data_aligner.sv
// Memory-load aligner: MOV/MFC handshake with word-wide memory, alignment
// check, lane extraction and double-word assembly, with per-access timeout.
// Optional build macro LOAD_ROTATE_EN: unaligned word loads rotate instead of
// faulting.
module load_data_aligner
    import arm_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = 8
) (
    input logic                Clk,
    input logic                CLR,
    load_data_aligner_if.slave bus
);

`ifdef LOAD_ROTATE_EN
    localparam logic ROT_EN = 1'b1;
`else
    localparam logic ROT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [1:0]        off_q, off_d;
    size_t             size_q, size_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] memaddr_q, memaddr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] datahi_q, datahi_d;
    logic [1:0]        sizeout_q, sizeout_d;
    logic              busy_q, busy_d;
    logic              mov_q, mov_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] lane_c;
    logic              timed_out_c;

    lane_extract u_lane (
        .word     (bus.MemData),
        .offset   (off_q),
        .size     (size_q),
        .rot_en   (ROT_EN),
        .result_c (lane_c)
    );

    // Saturating access-cycle count and its timeout decision.
    always_comb begin
        cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        timed_out_c = (cnt_inc >= CNT_LIMIT);
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        size_d    = size_q;
        lo_d      = lo_q;
        memaddr_d = memaddr_q;
        data_d    = data_q;
        datahi_d  = datahi_q;
        sizeout_d = sizeout_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.Start) begin
                    off_d  = bus.Addr[1:0];
                    size_d = size_t'(bus.dataSize);
                    if (is_aligned(size_t'(bus.dataSize), bus.Addr[2:0], ROT_EN)) begin
                        memaddr_d = {bus.Addr[ADDR_W-1:2], 2'b00};
                        state_d   = ST_REQ0;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_REQ0: begin
                if (bus.MFC) begin
                    cnt_d = '0;
                    if (size_q == DWORD) begin
                        lo_d      = lane_c;
                        memaddr_d = memaddr_q + ADDR_W'(4);
                        state_d   = ST_REQ1;
                    end else begin
                        data_d    = lane_c;
                        datahi_d  = '0;
                        sizeout_d = size_q;
                        state_d   = ST_DONE;
                    end
                end else if (timed_out_c) begin
                    cnt_d   = '0;
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REQ1: begin
                if (bus.MFC) begin
                    cnt_d     = '0;
                    data_d    = lo_q;
                    datahi_d  = bus.MemData;
                    sizeout_d = size_q;
                    state_d   = ST_DONE;
                end else if (timed_out_c) begin
                    cnt_d   = '0;
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        mov_d  = (state_d == ST_REQ0) || (state_d == ST_REQ1);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge Clk) begin
        if (CLR) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            off_q     <= '0;
            size_q    <= BYTE;
            lo_q      <= '0;
            memaddr_q <= '0;
            data_q    <= '0;
            datahi_q  <= '0;
            sizeout_q <= '0;
            busy_q    <= 1'b0;
            mov_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            off_q     <= off_d;
            size_q    <= size_d;
            lo_q      <= lo_d;
            memaddr_q <= memaddr_d;
            data_q    <= data_d;
            datahi_q  <= datahi_d;
            sizeout_q <= sizeout_d;
            busy_q    <= busy_d;
            mov_q     <= mov_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.MOV     = mov_q;
    assign bus.MemAddr = memaddr_q;
    assign bus.Data    = data_q;
    assign bus.DataHi  = datahi_q;
    assign bus.SizeOut = sizeout_q;
    assign bus.Done    = done_q;
    assign bus.Err     = err_q;

endmodule
